// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a requesting controller and the bit-serial adder.
// The master issues start/operands and the slave returns busy/done and the registered result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused for every bit, LSB first,
// which gives a WIDTH-cycle add with a start/busy/done handshake.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             s1;
   logic             c1;
   logic             s;
   logic             c2;
   logic             carry_next;

   // Shared adder cell: two half-adder stages feeding a carry OR.
   always_comb begin
      s1         = sa[0] ^ sb[0];
      c1         = sa[0] & sb[0];
      s          = s1 ^ carry;
      c2         = s1 & carry;
      carry_next = c1 | c2;
      res_next   = WIDTH'({s, res} >> 1);
      last       = (cnt == LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
      bus.sum  = sum_q;
      bus.cout = cout_q;
   end

   // The counter holds at WIDTH-1 on the final edge, so it never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa    <= bus.a;
                  sb    <= bus.b;
                  carry <= bus.cin;
                  res   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               res   <= res_next;
               carry <= carry_next;
               if (last) begin
                  sum_q  <= res_next;
                  cout_q <= carry_next;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
